// File: rtl/pgm_rcv.sv
// Far-end receiver/checker for the packet generator stream: frame parsing, statistics, latency max.
// Optional payload checking is enabled with `define PGM_RCV_PAYLOAD_CHK_EN.
module pgm_rcv #(
  parameter int unsigned SEQ_LSB  = 32,
  parameter int unsigned TS_LSB   = 0,
  parameter logic [15:0] DRAIN_TO = 16'd1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [133:0] in_rcv_data,
  input  logic         in_rcv_data_wr,
  input  logic         in_rcv_valid_wr,
  input  logic         in_rcv_valid,
  output logic         out_rcv_alf,
  input  logic         in_sent_start_flag,
  input  logic         in_sent_finish_flag,
  output logic [31:0]  out_pkt_cnt,
  output logic [47:0]  out_byte_cnt,
  output logic [15:0]  out_drop_cnt,
  output logic [15:0]  out_frame_err_cnt,
  output logic [15:0]  out_seq_err_cnt,
  output logic [31:0]  out_lat_max,
  output logic [15:0]  out_pay_err_cnt,
  output logic         out_rcv_busy,
  output logic         out_rcv_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} ctl_state_t;
  typedef enum logic [1:0] {F_IDLE, F_PKT, F_WAITV} frm_state_t;

  ctl_state_t r_cstate;
  frm_state_t r_fstate, w_fnext;
  logic [31:0] r_timer, r_seq, r_lat, r_pend, r_exp_seq;
  logic [15:0] r_drain;
  logic        r_busy, r_done;
  logic [31:0] r_pkt_cnt, r_lat_max;
  logic [47:0] r_byte_cnt;
  logic [15:0] r_drop_cnt, r_frame_err_cnt, r_seq_err_cnt;

  logic        w_head, w_mid, w_tail, w_body;
  logic [3:0]  w_inv;
  logic [31:0] w_hd_seq, w_hd_lat, w_tail_bytes;
  logic [31:0] w_pend_nxt, w_res_bytes;
  logic        w_latch, w_err, w_res;
  logic [48:0] w_byte_sum;

  assign w_head       = in_rcv_data_wr && (in_rcv_data[133:132] == 2'b01);
  assign w_mid        = in_rcv_data_wr && (in_rcv_data[133:132] == 2'b11);
  assign w_tail       = in_rcv_data_wr && (in_rcv_data[133:132] == 2'b10);
  assign w_body       = w_mid || w_tail;
  assign w_inv        = in_rcv_data[131:128];
  assign w_hd_seq     = in_rcv_data[SEQ_LSB +: 32];
  // Latency is taken when the head arrives and applied when the packet resolves.
  assign w_hd_lat     = r_timer - in_rcv_data[TS_LSB +: 32];
  assign w_tail_bytes = 32'd16 - {28'd0, w_inv};
  assign w_byte_sum   = {1'b0, r_byte_cnt} + {17'd0, w_res_bytes};

  always_comb begin
    w_fnext     = r_fstate;
    w_pend_nxt  = r_pend;
    w_res_bytes = r_pend;
    w_latch     = 1'b0;
    w_err       = 1'b0;
    w_res       = 1'b0;
    unique case (r_fstate)
      F_IDLE: begin
        if (w_head) begin
          w_latch = 1'b1;
          w_fnext = F_PKT;
        end else if (w_body) w_err = 1'b1;
        if (in_rcv_valid_wr) w_err = 1'b1;
      end
      F_PKT: begin
        if (w_head) begin
          w_err   = 1'b1;
          w_latch = 1'b1;
        end else if (w_mid) begin
          w_pend_nxt = r_pend + 32'd16;
        end else if (w_tail) begin
          w_res_bytes = r_pend + w_tail_bytes;
          w_pend_nxt  = w_res_bytes;
          if (in_rcv_valid_wr) begin
            w_res   = 1'b1;
            w_fnext = F_IDLE;
          end else w_fnext = F_WAITV;
        end
        if (in_rcv_valid_wr && !w_tail) w_err = 1'b1;
      end
      F_WAITV: begin
        // A head without the status strobe abandons the pending packet.
        if (in_rcv_valid_wr) begin
          w_res   = 1'b1;
          w_fnext = F_IDLE;
        end else if (w_head) w_err = 1'b1;
        if (w_head) begin
          w_latch = 1'b1;
          w_fnext = F_PKT;
        end else if (w_body) w_err = 1'b1;
      end
      default: w_fnext = F_IDLE;
    endcase
    if (w_latch) w_pend_nxt = 32'd16;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer  <= '0;
      r_fstate <= F_IDLE;
      r_pend   <= '0;
      r_seq    <= '0;
      r_lat    <= '0;
    end else begin
      r_timer  <= r_timer + 32'd1;
      r_fstate <= w_fnext;
      r_pend   <= w_pend_nxt;
      if (w_latch) begin
        r_seq <= w_hd_seq;
        r_lat <= w_hd_lat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cstate <= IDLE;
      r_drain  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (in_sent_start_flag) begin
      r_cstate <= RUN;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      unique case (r_cstate)
        RUN: if (in_sent_finish_flag) begin
          r_cstate <= DRAIN;
          r_drain  <= DRAIN_TO;
        end
        DRAIN: begin
          if (r_fstate == F_IDLE || r_drain <= 16'd1) begin
            r_cstate <= DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else r_drain <= r_drain - 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt       <= '0;
      r_byte_cnt      <= '0;
      r_drop_cnt      <= '0;
      r_frame_err_cnt <= '0;
      r_seq_err_cnt   <= '0;
      r_lat_max       <= '0;
      r_exp_seq       <= '0;
    end else if (in_sent_start_flag) begin
      r_pkt_cnt       <= '0;
      r_byte_cnt      <= '0;
      r_drop_cnt      <= '0;
      r_frame_err_cnt <= '0;
      r_seq_err_cnt   <= '0;
      r_lat_max       <= '0;
      r_exp_seq       <= '0;
    end else if (r_busy) begin
      if (w_err && r_frame_err_cnt != '1) r_frame_err_cnt <= r_frame_err_cnt + 16'd1;
      if (w_res) begin
        if (in_rcv_valid) begin
          if (r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + 32'd1;
          r_byte_cnt <= w_byte_sum[48] ? '1 : w_byte_sum[47:0];
          if (r_seq != r_exp_seq && r_seq_err_cnt != '1) r_seq_err_cnt <= r_seq_err_cnt + 16'd1;
          r_exp_seq <= r_seq + 32'd1;
          if (r_lat > r_lat_max) r_lat_max <= r_lat;
        end else if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

`ifdef PGM_RCV_PAYLOAD_CHK_EN
  logic [127:0] w_pay_exp, w_pay_mask;
  logic         w_pay_word_bad, w_pay_bad, r_pay_bad;
  logic [15:0]  r_pay_err_cnt;

  // On the tail only the valid (most-significant) bytes are compared.
  assign w_pay_exp      = {4{r_seq}};
  assign w_pay_mask     = w_tail ? ({128{1'b1}} << {w_inv, 3'b000}) : {128{1'b1}};
  assign w_pay_word_bad = (r_fstate == F_PKT) && w_body &&
                          (|((in_rcv_data[127:0] ^ w_pay_exp) & w_pay_mask));
  assign w_pay_bad      = r_pay_bad || w_pay_word_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pay_bad     <= 1'b0;
      r_pay_err_cnt <= '0;
    end else begin
      r_pay_bad <= w_latch ? 1'b0 : w_pay_bad;
      if (in_sent_start_flag) r_pay_err_cnt <= '0;
      else if (r_busy && w_res && w_pay_bad && r_pay_err_cnt != '1)
        r_pay_err_cnt <= r_pay_err_cnt + 16'd1;
    end
  end

  assign out_pay_err_cnt = r_pay_err_cnt;
`else
  logic w_unused;
  assign w_unused        = ^in_rcv_data[127:0];
  assign out_pay_err_cnt = 16'd0;
`endif

  assign out_rcv_alf       = 1'b0;
  assign out_pkt_cnt       = r_pkt_cnt;
  assign out_byte_cnt      = r_byte_cnt;
  assign out_drop_cnt      = r_drop_cnt;
  assign out_frame_err_cnt = r_frame_err_cnt;
  assign out_seq_err_cnt   = r_seq_err_cnt;
  assign out_lat_max       = r_lat_max;
  assign out_rcv_busy      = r_busy;
  assign out_rcv_done      = r_done;

endmodule
